mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Upstream program loader for `pipe_MIPS32`. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Writes each word to sequential instruction-memory addresses from 0 upward. On the HLT word (`32'hfc000000`), ends the load and pulses `cpu_start` to release the CPU, with PC cleared and HALTED cleared by the CPU-side glue.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `clk1`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `load_req`  in  1  start a load; sampled only in IDLE, DONE, ERR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data, most significant byte of each word first.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_W  write word address.
- `mem_wdata`  out  32  write data.
- `cpu_start`  out  1  one-cycle pulse: program loaded, CPU may run.
- `busy`  out  1  high in RECV and WRITE.
- `done`  out  1  high in DONE.
- `overflow_err`  out  1  high in ERR.
- `word_count`  out  ADDR_W+1  words written in the current or last load, including HLT.

## Operation
- States are IDLE, RECV, WRITE, DONE, ERR.
- Reset value of every output and register is 0, and the state is IDLE. Reset mid-load aborts immediately. Words already written to memory are not undone.
- IDLE:
  - `in_ready`=0.
  - `load_req`=1 → RECV. Clear `addr`, `byte_cnt`, `word_count`.
- RECV:
  - `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) does `word <= {word[23:0], in_data}` and `byte_cnt++`. `byte_cnt` is 2 bits and wraps.
  - The handshake that accepts the 4th byte (`byte_cnt`==3) → WRITE.
  - `in_valid`=0 holds state; gaps of any length are allowed.
- WRITE:
  - `in_ready`=0, `mem_we`=1, `mem_addr`=`addr`, `mem_wdata`=`word`, `word_count++`.
  - If `word`==`32'hfc000000` → DONE. This check takes priority over the overflow check.
  - Else if `addr`==2^ADDR_W−1 → ERR. The last word is still written.
  - Else `addr++` → RECV.
- DONE:
  - `cpu_start`=1 only in the first cycle of DONE. `done`=1 for the whole state.
  - `load_req` → RECV with counters cleared (reload). `cpu_start` is not re-asserted until the next HLT.
- ERR:
  - `overflow_err`=1, no `cpu_start`.
  - `load_req` → RECV with counters cleared.
- `load_req` is ignored in RECV and WRITE.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0. Only `mem_we` is qualifying.

## Timing
- `in_ready` is a registered function of state. It is never combinationally dependent on `in_valid`.
- Latency: 4th-byte handshake at edge N → `mem_we`=1 in cycle N+1.
- HLT write in cycle N+1 → `cpu_start` in cycle N+2.
- Maximum throughput is 1 word per 5 cycles: 4 RECV cycles plus 1 WRITE cycle.
- `load_req` in IDLE at edge N → `in_ready`=1 in cycle N+1.
- `word_count` updates at the end of the WRITE cycle and is visible the cycle after `mem_we`.
- `rst_n`=0 takes effect at the next edge and overrides `load_req` and handshakes in the same cycle.

## Test plan
- **Full program load.** Pulse `load_req`, then stream these 36 bytes back-to-back:
  - `28 01 00 0a`, `28 02 00 14`, `28 03 00 19`
  - `0c e7 78 00` ×2, `00 22 20 00`, `0c e7 78 00`, `00 83 28 00`
  - `fc 00 00 00`

  Required response:
  - 9 `mem_we` pulses at addr 0..8 with the matching words, e.g. addr 0 = `2801000a`, addr 8 = `fc000000`.
  - `cpu_start` a single pulse one cycle after the addr-8 write.
  - `word_count`=9, `done`=1.
- **Valid gaps.** Same stream with `in_valid` low for 3 cycles between every byte → identical memory writes and `word_count`. No byte dropped or duplicated.
- **Reset mid-word.** Apply `rst_n`=0 for one cycle after 2 bytes of word 1 → state IDLE, all outputs 0, no `mem_we`. A new load then writes addr 0 = first complete word.
- **Overflow, `ADDR_W`=2.** Stream 4 non-HLT words → writes to addr 0..3, then `overflow_err`=1, `word_count`=4, no `cpu_start`, `in_ready`=0.
- **Ignored request and HLT priority.**
  - `load_req` asserted during RECV → no counter clear.
  - With `ADDR_W`=2, HLT as the 4th word → DONE, not ERR.
- **Reload.** `load_req` in DONE, stream `00 22 20 00 fc 00 00 00` → writes addr 0,1, `word_count`=2, exactly one new `cpu_start` pulse.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// -----------------------------------------------------------------------------
// mips32_prog_loader
//
// Program loader that sits in front of pipe_MIPS32. It takes a byte stream,
// builds big-endian 32-bit instruction words and writes them to instruction
// memory at word addresses 0, 1, 2, ... When it writes the HLT word
// (32'hfc000000), the load ends and cpu_start pulses for one cycle so that
// the CPU-side glue can clear PC and HALTED and release the core.
//
// Ports
//   clk1          single clock, rising edge
//   rst_n         synchronous active-low reset
//   load_req      start a load (sampled in IDLE, DONE and ERR only)
//   in_valid      byte-stream valid
//   in_data[7:0]  byte-stream data, most significant byte of each word first
//   in_ready      loader accepts a byte this cycle
//   mem_we        instruction-memory write enable, one cycle per word
//   mem_addr      write word address (holds its value between writes)
//   mem_wdata     write data (holds its value between writes)
//   cpu_start     one-cycle pulse after the HLT word has been written
//   busy          loader is in RECV or WRITE
//   done          loader is in DONE
//   overflow_err  loader is in ERR (memory filled without an HLT word)
//   word_count    words written in the current or last load, HLT included
//
// Handshake: a byte moves on a rising edge where in_valid and in_ready are
// both high. in_ready depends only on the state register and never on
// in_valid, so the producer may hold in_valid low for any number of cycles
// and a byte is never dropped or taken twice.
// -----------------------------------------------------------------------------
module mips32_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [31:0] HLT_WORD = 32'hfc000000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [31:0]       word_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_start_q;

    logic              hs;
    logic              last_byte;
    logic              is_hlt;
    logic              last_addr;
    logic [31:0]       word_next;

    assign hs        = in_valid && (state_q == S_RECV);
    assign last_byte = (byte_cnt_q == 2'd3);
    assign is_hlt    = (word_q == HLT_WORD);
    assign last_addr = (addr_q == {ADDR_W{1'b1}});
    assign word_next = {word_q[23:0], in_data};

    // State register and datapath.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req) begin
                        addr_q     <= '0;
                        byte_cnt_q <= '0;
                        count_q    <= '0;
                    end
                end
                S_RECV: begin
                    if (hs) begin
                        word_q     <= word_next;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // The memory-facing address/data registers load only
                        // when a word completes, so they hold steady between
                        // writes while the next word is shifting in.
                        if (last_byte) begin
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= word_next;
                        end
                    end
                end
                S_WRITE: begin
                    count_q <= count_q + (ADDR_W+1)'(1);
                    // HLT wins over the full-memory check, so an HLT in the
                    // very last slot still ends the load cleanly.
                    if (is_hlt) begin
                        cpu_start_q <= 1'b1;
                    end else if (!last_addr) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        overflow_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_req) state_d = S_RECV;
            end
            S_RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs && last_byte) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (is_hlt)         state_d = S_DONE;
                else if (last_addr) state_d = S_ERR;
                else                state_d = S_RECV;
            end
            S_DONE: begin
                done = 1'b1;
                if (load_req) state_d = S_RECV;
            end
            S_ERR: begin
                overflow_err = 1'b1;
                if (load_req) state_d = S_RECV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_start  = cpu_start_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_mips32_prog_loader
//
// Bench for mips32_prog_loader. Two instances share clock and reset: dut0 with
// the default 10-bit address and dut1 with a 2-bit address (4-word memory)
// for the overflow and HLT-in-last-slot cases. Memory writes are checked by a
// monitor per instance against an expected queue of {addr, data}.
// -----------------------------------------------------------------------------
module tb_mips32_prog_loader;

  localparam logic [31:0] HLT = 32'hfc000000;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rst_n;

  // dut0: ADDR_W = 10
  logic        lr0, iv0, ir0, we0, cs0, busy0, done0, ovf0;
  logic [7:0]  id0;
  logic [9:0]  addr0;
  logic [31:0] wdata0;
  logic [10:0] wc0;

  // dut1: ADDR_W = 2
  logic        lr1, iv1, ir1, we1, cs1, busy1, done1, ovf1;
  logic [7:0]  id1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [2:0]  wc1;

  mips32_prog_loader #(.ADDR_W(10)) dut0 (
    .clk1(clk1), .rst_n(rst_n), .load_req(lr0), .in_valid(iv0), .in_data(id0),
    .in_ready(ir0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .cpu_start(cs0), .busy(busy0), .done(done0), .overflow_err(ovf0),
    .word_count(wc0)
  );

  mips32_prog_loader #(.ADDR_W(2)) dut1 (
    .clk1(clk1), .rst_n(rst_n), .load_req(lr1), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .cpu_start(cs1), .busy(busy1), .done(done1), .overflow_err(ovf1),
    .word_count(wc1)
  );

  int total = 0;
  int bad = 0;
  int sel = 0;
  int start_cnt0 = 0;
  int start_cnt1 = 0;
  logic hlt_prev0 = 1'b0;
  logic hlt_prev1 = 1'b0;
  logic [41:0] exp0_q[$];
  logic [41:0] exp1_q[$];
  logic [41:0] e0, e1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk1) begin
    if (cs0 || hlt_prev0) check("cpu_start0_timing", 64'(cs0), 64'(hlt_prev0));
    if (cs0) start_cnt0++;
    hlt_prev0 = we0 && (wdata0 == HLT);
    if (we0) begin
      if (exp0_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write0: got addr=%0h data=%0h want no write", addr0, wdata0);
      end else begin
        e0 = exp0_q.pop_front();
        check("write0", 64'({addr0, wdata0}), 64'(e0));
      end
    end
  end

  always @(negedge clk1) begin
    if (cs1 || hlt_prev1) check("cpu_start1_timing", 64'(cs1), 64'(hlt_prev1));
    if (cs1) start_cnt1++;
    hlt_prev1 = we1 && (wdata1 == HLT);
    if (we1) begin
      if (exp1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write1: got addr=%0h data=%0h want no write", addr1, wdata1);
      end else begin
        e1 = exp1_q.pop_front();
        check("write1", 64'({8'h00, addr1, wdata1}), 64'(e1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [7:0] d);
    if (sel == 0) begin iv0 = v; id0 = d; end
    else begin iv1 = v; id1 = d; end
  endtask

  function automatic logic cur_ready();
    return (sel == 0) ? ir0 : ir1;
  endfunction

  function automatic logic cur_we();
    return (sel == 0) ? we0 : we1;
  endfunction

  task automatic pulse_load();
    if (sel == 0) lr0 = 1'b1; else lr1 = 1'b1;
    @(negedge clk1);
    lr0 = 1'b0;
    lr1 = 1'b0;
  endtask

  // Offers one byte; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    set_in(1'b1, b);
    while (!cur_ready() && n < 50) begin
      @(negedge clk1);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL ready_timeout: got in_ready=0 for 50 cycles want 1");
    end
    @(negedge clk1);
    set_in(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [9:0] a, input int gap);
    if (sel == 0) exp0_q.push_back({a, w}); else exp1_q.push_back({a, w});
    send_byte(w[31:24]); repeat (gap) @(negedge clk1);
    send_byte(w[23:16]); repeat (gap) @(negedge clk1);
    send_byte(w[15:8]);  repeat (gap) @(negedge clk1);
    send_byte(w[7:0]);
    // Fourth byte taken at the last edge: the write is in this cycle.
    check("we_latency", 64'(cur_we()), 64'd1);
    repeat (gap) @(negedge clk1);
  endtask

  task automatic check_reset0();
    check("rst_flags0", 64'({ir0, we0, cs0, busy0, done0, ovf0}), 64'd0);
    check("rst_addr0", 64'(addr0), 64'd0);
    check("rst_wdata0", 64'(wdata0), 64'd0);
    check("rst_wc0", 64'(wc0), 64'd0);
  endtask

  typedef struct {
    logic [31:0] w;
    logic [9:0]  a;
  } vec_t;

  vec_t prog[9];
  int   base;

  initial begin
    prog[0] = '{32'h2801000a, 10'd0};
    prog[1] = '{32'h28020014, 10'd1};
    prog[2] = '{32'h28030019, 10'd2};
    prog[3] = '{32'h0ce77800, 10'd3};
    prog[4] = '{32'h0ce77800, 10'd4};
    prog[5] = '{32'h00222000, 10'd5};
    prog[6] = '{32'h0ce77800, 10'd6};
    prog[7] = '{32'h00832800, 10'd7};
    prog[8] = '{HLT,          10'd8};

    rst_n = 1'b0;
    lr0 = 1'b0; iv0 = 1'b0; id0 = 8'h00;
    lr1 = 1'b0; iv1 = 1'b0; id1 = 8'h00;

    // ---- clock/reset ----
    repeat (2) @(negedge clk1);
    check_reset0();
    check("rst_flags1", 64'({ir1, we1, cs1, busy1, done1, ovf1, wc1}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk1);
    check("idle_ready0", 64'(ir0), 64'd0);

    // ---- full program load, back-to-back ----
    sel = 0;
    pulse_load();
    check("load_ready0", 64'({ir0, busy0}), 64'b11);
    for (int i = 0; i < 9; i++) send_word(prog[i].w, prog[i].a, 0);
    repeat (3) @(negedge clk1);
    check("full_done", 64'({done0, busy0, ir0, ovf0}), 64'b1000);
    check("full_wc", 64'(wc0), 64'd9);
    check("full_q_empty", 64'(exp0_q.size()), 64'd0);
    check("full_start_cnt", 64'(start_cnt0), 64'd1);

    // ---- valid gaps, plus load_req ignored in RECV ----
    pulse_load();
    check("reload_wc_clear", 64'(wc0), 64'd0);
    for (int i = 0; i < 9; i++) begin
      send_word(prog[i].w, prog[i].a, 3);
      if (i == 1) begin
        pulse_load();
        check("ignored_req_wc", 64'(wc0), 64'd2);
        check("ignored_req_ready", 64'(ir0), 64'd1);
      end
    end
    repeat (3) @(negedge clk1);
    check("gap_wc", 64'(wc0), 64'd9);
    check("gap_done", 64'(done0), 64'd1);
    check("gap_q_empty", 64'(exp0_q.size()), 64'd0);
    check("gap_start_cnt", 64'(start_cnt0), 64'd2);

    // ---- reset mid-word ----
    pulse_load();
    send_byte(8'h28);
    send_byte(8'h01);
    rst_n = 1'b0;
    @(negedge clk1);
    check_reset0();
    rst_n = 1'b1;
    @(negedge clk1);
    check("post_rst_idle", 64'({ir0, busy0, done0}), 64'd0);
    base = start_cnt0;
    pulse_load();
    send_word(32'h00222000, 10'd0, 0);
    send_word(HLT, 10'd1, 0);
    repeat (3) @(negedge clk1);
    check("post_rst_wc", 64'(wc0), 64'd2);
    check("post_rst_start", 64'(start_cnt0 - base), 64'd1);

    // ---- reload from DONE ----
    base = start_cnt0;
    pulse_load();
    check("reload_state", 64'({ir0, done0, wc0}), 64'({1'b1, 1'b0, 11'd0}));
    send_word(32'h00222000, 10'd0, 0);
    send_word(HLT, 10'd1, 0);
    repeat (5) @(negedge clk1);
    check("reload_wc", 64'(wc0), 64'd2);
    check("reload_start", 64'(start_cnt0 - base), 64'd1);
    check("reload_q_empty", 64'(exp0_q.size()), 64'd0);

    // ---- overflow with 4-word memory ----
    sel = 1;
    pulse_load();
    send_word(32'h11111111, 10'd0, 0);
    send_word(32'h22222222, 10'd1, 0);
    send_word(32'h33333333, 10'd2, 1);
    send_word(32'h44444444, 10'd3, 0);
    repeat (3) @(negedge clk1);
    check("ovf_flags", 64'({ovf1, done1, busy1, ir1}), 64'b1000);
    check("ovf_wc", 64'(wc1), 64'd4);
    check("ovf_no_start", 64'(start_cnt1), 64'd0);
    check("ovf_addr_hold", 64'({addr1, wdata1}), 64'({2'd3, 32'h44444444}));

    // ---- restart from ERR, HLT in the last slot ----
    pulse_load();
    check("err_reload", 64'({ovf1, ir1, wc1}), 64'({1'b0, 1'b1, 3'd0}));
    send_word(32'h0ce77800, 10'd0, 0);
    send_word(32'h00832800, 10'd1, 0);
    send_word(32'h28010005, 10'd2, 0);
    send_word(HLT, 10'd3, 0);
    repeat (3) @(negedge clk1);
    check("hlt_prio_flags", 64'({done1, ovf1}), 64'b10);
    check("hlt_prio_wc", 64'(wc1), 64'd4);
    check("hlt_prio_start", 64'(start_cnt1), 64'd1);
    check("q1_empty", 64'(exp1_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
